lcd_char_writer: RTL and testbench



---
 rtl/lcd_char_writer_if.sv | 11 +
 rtl/lcd_char_writer.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_char_writer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_char_writer_if.sv
// Byte-input handshake between the hex-to-LCD decoder and lcd_char_writer.
// Each byte carries a flag saying whether it is a character or a raw LCD command.
interface lcd_char_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_cmd;

    modport master (output in_valid, output in_data, output in_is_cmd, input in_ready);
    modport slave  (input in_valid, input in_data, input in_is_cmd, output in_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 8-bit write-only driver: power-up init, timed E strobes, cursor tracking
// and an automatic DDRAM address write whenever a line fills up.
module lcd_char_writer #(
    parameter int POWERUP_CYC    = 750000,
    parameter int SETUP_CYC      = 2,
    parameter int E_HIGH_CYC     = 12,
    parameter int HOLD_CYC       = 2,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int COLS           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_char_writer_if.slave  in_if,
    output logic              init_done,
    output logic              cur_row,
    output logic [3:0]        cur_col,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic [7:0]        lcd_data
);
    localparam int MAX_1 = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_2 = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
    localparam int MAX_3 = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAX_4 = (MAX_1 > MAX_2) ? MAX_1 : MAX_2;
    localparam int MAX_C = (MAX_4 > MAX_3) ? MAX_4 : MAX_3;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_SETUP   = 3'd3;
    localparam logic [2:0] ST_EHIGH   = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;
    localparam logic [2:0] ST_WAIT    = 3'd6;

    function automatic logic is_clr_cmd(input logic [7:0] d);
        return (d == 8'h01) || (d == 8'h02);
    endfunction

    function automatic logic [3:0] clamp_col(input logic [3:0] c);
        logic [3:0] res;
        if (int'(c) >= COLS) begin
            res = 4'(COLS - 1);
        end else begin
            res = c;
        end
        return res;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] res;
        case (step)
            2'd0:    res = 8'h38;
            2'd1:    res = 8'h0C;
            2'd2:    res = 8'h01;
            2'd3:    res = 8'h06;
            default: res = 8'h06;
        endcase
        return res;
    endfunction

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_step;
    logic             r_init_done;
    logic             r_ready;
    logic             r_row;
    logic [3:0]       r_col;
    logic             r_pending;
    logic             r_clr_wait;
    logic             r_e;
    logic             r_rs;
    logic [7:0]       r_data;

    logic             w_accept;
    logic             w_cnt_zero;
    logic [4:0]       w_col_inc;
    logic             w_col_wrap;

    assign w_accept   = in_if.in_valid & r_ready;
    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});
    assign w_col_inc  = {1'b0, r_col} + 5'd1;
    assign w_col_wrap = (int'(w_col_inc) == COLS);

    // Sequencer: one shared down-counter times every state; bus and cursor registers update with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_POWERUP;
            r_cnt       <= CNT_W'(POWERUP_CYC - 1);
            r_step      <= 2'd0;
            r_init_done <= 1'b0;
            r_ready     <= 1'b0;
            r_row       <= 1'b0;
            r_col       <= 4'd0;
            r_pending   <= 1'b0;
            r_clr_wait  <= 1'b0;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            case (r_state)
                ST_POWERUP: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_INIT;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_INIT: begin
                    r_rs       <= 1'b0;
                    r_data     <= init_cmd(r_step);
                    r_clr_wait <= is_clr_cmd(init_cmd(r_step));
                    r_cnt      <= CNT_W'(SETUP_CYC - 1);
                    r_state    <= ST_SETUP;
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready    <= 1'b0;
                        r_rs       <= ~in_if.in_is_cmd;
                        r_data     <= in_if.in_data;
                        r_clr_wait <= in_if.in_is_cmd & is_clr_cmd(in_if.in_data);
                        r_cnt      <= CNT_W'(SETUP_CYC - 1);
                        r_state    <= ST_SETUP;
                        if (!in_if.in_is_cmd) begin
                            if (w_col_wrap) begin
                                r_col     <= 4'd0;
                                r_row     <= ~r_row;
                                r_pending <= 1'b1;
                            end else begin
                                r_col <= w_col_inc[3:0];
                            end
                        end else if (is_clr_cmd(in_if.in_data)) begin
                            r_row <= 1'b0;
                            r_col <= 4'd0;
                        end else if (in_if.in_data[7]) begin
                            r_row <= in_if.in_data[6];
                            r_col <= clamp_col(in_if.in_data[3:0]);
                        end else begin
                            r_col <= r_col;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_zero) begin
                        r_e     <= 1'b1;
                        r_cnt   <= CNT_W'(E_HIGH_CYC - 1);
                        r_state <= ST_EHIGH;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_EHIGH: begin
                    if (w_cnt_zero) begin
                        r_e     <= 1'b0;
                        r_cnt   <= CNT_W'(HOLD_CYC - 1);
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= r_clr_wait ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_WAIT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (!r_init_done) begin
                        if (r_step == 2'd3) begin
                            r_init_done <= 1'b1;
                            r_ready     <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_state <= ST_INIT;
                        end
                    end else if (r_pending) begin
                        // Row was already toggled at acceptance, so it names the line to move to.
                        r_pending  <= 1'b0;
                        r_rs       <= 1'b0;
                        r_data     <= r_row ? 8'hC0 : 8'h80;
                        r_clr_wait <= 1'b0;
                        r_cnt      <= CNT_W'(SETUP_CYC - 1);
                        r_state    <= ST_SETUP;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_POWERUP;
                    r_cnt   <= CNT_W'(POWERUP_CYC - 1);
                    r_e     <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = r_ready;
    assign init_done      = r_init_done;
    assign cur_row        = r_row;
    assign cur_col        = r_col;
    assign lcd_e          = r_e;
    assign lcd_rs         = r_rs;
    assign lcd_rw         = 1'b0;
    assign lcd_data       = r_data;
endmodule

// File: tb/tb_lcd_char_writer.sv
// Self-checking bench for lcd_char_writer: directed vector table, init/reset sequences,
// randomized traffic against a position-arithmetic reference model, and a COLS=8 instance.
module tb_lcd_char_writer;
    localparam int P_PWR = 20, P_SU = 1, P_EH = 2, P_HO = 1, P_CW = 4, P_CLW = 10, P_COLS = 16;
    localparam int BOUND = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_char_writer_if ifa ();
    lcd_char_writer_if ifb ();

    logic       a_init, a_row, a_e, a_rs, a_rw;
    logic [3:0] a_col;
    logic [7:0] a_data;
    logic       b_init, b_row, b_e, b_rs, b_rw;
    logic [3:0] b_col;
    logic [7:0] b_data;

    lcd_char_writer #(.POWERUP_CYC(P_PWR), .SETUP_CYC(P_SU), .E_HIGH_CYC(P_EH), .HOLD_CYC(P_HO),
                      .CMD_WAIT_CYC(P_CW), .CLEAR_WAIT_CYC(P_CLW), .COLS(P_COLS)) dut (
        .clk(clk), .rst_n(rst_n), .in_if(ifa.slave), .init_done(a_init), .cur_row(a_row),
        .cur_col(a_col), .lcd_e(a_e), .lcd_rs(a_rs), .lcd_rw(a_rw), .lcd_data(a_data));

    lcd_char_writer #(.POWERUP_CYC(P_PWR), .SETUP_CYC(P_SU), .E_HIGH_CYC(P_EH), .HOLD_CYC(P_HO),
                      .CMD_WAIT_CYC(P_CW), .CLEAR_WAIT_CYC(P_CLW), .COLS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_if(ifb.slave), .init_done(b_init), .cur_row(b_row),
        .cur_col(b_col), .lcd_e(b_e), .lcd_rs(b_rs), .lcd_rw(b_rw), .lcd_data(b_data));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: record every E rising edge with its {rs,data} and cycle stamp.
    int         cyc = 0;
    logic       e_prev = 1'b0;
    logic [8:0] e_lat = 9'h000;
    logic [8:0] pq[$];
    int         sq[$];
    int         stab_err = 0, ready_err = 0, rw_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_e && !e_prev) begin
            pq.push_back({a_rs, a_data});
            sq.push_back(cyc);
            e_lat <= {a_rs, a_data};
        end else if (a_e && ({a_rs, a_data} != e_lat)) begin
            stab_err <= stab_err + 1;
        end
        if (ifa.in_ready && !a_init) ready_err <= ready_err + 1;
        if (a_rw !== 1'b0 || b_rw !== 1'b0) rw_err <= rw_err + 1;
        e_prev <= a_e;
    end

    // Reference cursor as a linear position over a 2 x COLS screen.
    int m_row = 0, m_col = 0;

    function automatic void model(input logic c, input logic [7:0] d, output int lat, output logic wrap);
        int pos;
        logic clr;
        wrap = 1'b0;
        clr  = c && (d == 8'h01 || d == 8'h02);
        if (!c) begin
            pos   = m_row * P_COLS + m_col + 1;
            wrap  = (pos % P_COLS) == 0;
            pos   = pos % (2 * P_COLS);
            m_row = pos / P_COLS;
            m_col = pos % P_COLS;
        end else if (clr) begin
            m_row = 0;
            m_col = 0;
        end else if (d[7]) begin
            m_row = int'(d[6]);
            m_col = (int'(d[3:0]) >= P_COLS) ? P_COLS - 1 : int'(d[3:0]);
        end
        lat = 1 + P_SU + P_EH + P_HO + (clr ? P_CLW : P_CW) + (wrap ? P_SU + P_EH + P_HO + P_CW : 0);
    endfunction

    task automatic send_a(input logic c, input logic [7:0] d, input string tag, output int lat);
        int n;
        int e_bad;
        logic exp_e;
        pq.delete();
        sq.delete();
        @(negedge clk);
        ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_is_cmd = c;
        n = 0;
        while (!ifa.in_ready && n < BOUND) begin @(negedge clk); n++; end
        check({tag, " accept_timeout"}, 32'(n < BOUND), 32'd1);
        @(negedge clk);
        ifa.in_valid = 1'b0; ifa.in_data = 8'($urandom); ifa.in_is_cmd = 1'($urandom);
        check({tag, " rs_at_T+1"}, 32'(a_rs), 32'(!c));
        check({tag, " data_at_T+1"}, 32'(a_data), 32'(d));
        lat = 1;
        e_bad = 0;
        while (!ifa.in_ready && lat < BOUND) begin
            exp_e = (lat >= 1 + P_SU) && (lat <= P_SU + P_EH);
            if (lat < 1 + P_SU + P_EH + P_HO && a_e !== exp_e) e_bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, " e_window"}, 32'(e_bad), 32'd0);
    endtask

    task automatic do_txn(input logic c, input logic [7:0] d, input string tag);
        int lat, exp_lat;
        logic wrap;
        model(c, d, exp_lat, wrap);
        send_a(c, d, tag, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " row"}, 32'(a_row), 32'(m_row));
        check({tag, " col"}, 32'(a_col), 32'(m_col));
        check({tag, " npulses"}, 32'(pq.size()), wrap ? 32'd2 : 32'd1);
        check({tag, " pulse0"}, (pq.size() > 0) ? 32'(pq[0]) : 32'h1FF, 32'({!c, d}));
        if (wrap) check({tag, " line_cmd"}, (pq.size() > 1) ? 32'(pq[1]) : 32'h1FF,
                        (m_row == 1) ? 32'h0C0 : 32'h080);
    endtask

    task automatic check_init(input string tag);
        int t0, n;
        logic [8:0] exp_seq [4];
        exp_seq = '{9'h038, 9'h00C, 9'h001, 9'h006};
        t0 = cyc;
        n = 0;
        while (!a_init && n < BOUND) begin @(negedge clk); n++; end
        check({tag, " init_timeout"}, 32'(n < BOUND), 32'd1);
        check({tag, " init_npulses"}, 32'(pq.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check({tag, " init_pulse"}, (pq.size() > k) ? 32'(pq[k]) : 32'h1FF, 32'(exp_seq[k]));
        if (sq.size() >= 4) begin
            check({tag, " powerup_quiet"}, 32'((sq[0] - t0) >= P_PWR), 32'd1);
            check({tag, " clear_gap_extra"}, 32'((sq[3] - sq[2]) - (sq[1] - sq[0])), 32'(P_CLW - P_CW));
        end else begin
            check({tag, " init_stamps"}, 32'(sq.size()), 32'd4);
        end
        check({tag, " init_row"}, 32'(a_row), 32'd0);
        check({tag, " init_col"}, 32'(a_col), 32'd0);
    endtask

    task automatic send_b(input logic c, input logic [7:0] d, input logic exp_row, input logic [3:0] exp_col);
        int n;
        @(negedge clk);
        ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_is_cmd = c;
        n = 0;
        while (!ifb.in_ready && n < BOUND) begin @(negedge clk); n++; end
        @(negedge clk);
        ifb.in_valid = 1'b0;
        while (!ifb.in_ready && n < BOUND) begin @(negedge clk); n++; end
        check("b_timeout", 32'(n < BOUND), 32'd1);
        check("b_row", 32'(b_row), 32'(exp_row));
        check("b_col", 32'(b_col), 32'(exp_col));
    endtask

    typedef struct {
        logic       c;
        logic [7:0] d;
        logic       row;
        logic [3:0] col;
        int         lat;
        int         npulse;
        logic [8:0] p2;
    } vec_t;

    vec_t vt [12];

    initial begin
        int lat, n;
        vt[0]  = '{1'b1, 8'h01, 1'b0, 4'd0,  15, 1, 9'h000};
        vt[1]  = '{1'b0, 8'h35, 1'b0, 4'd1,   9, 1, 9'h000};
        vt[2]  = '{1'b1, 8'h85, 1'b0, 4'd5,   9, 1, 9'h000};
        vt[3]  = '{1'b1, 8'h01, 1'b0, 4'd0,  15, 1, 9'h000};
        vt[4]  = '{1'b1, 8'hC3, 1'b1, 4'd3,   9, 1, 9'h000};
        vt[5]  = '{1'b1, 8'h02, 1'b0, 4'd0,  15, 1, 9'h000};
        vt[6]  = '{1'b1, 8'h8F, 1'b0, 4'd15,  9, 1, 9'h000};
        vt[7]  = '{1'b0, 8'h41, 1'b1, 4'd0,  17, 2, 9'h0C0};
        vt[8]  = '{1'b1, 8'h0E, 1'b1, 4'd0,   9, 1, 9'h000};
        vt[9]  = '{1'b1, 8'hDF, 1'b1, 4'd15,  9, 1, 9'h000};
        vt[10] = '{1'b0, 8'h30, 1'b0, 4'd0,  17, 2, 9'h080};
        vt[11] = '{1'b1, 8'h06, 1'b0, 4'd0,   9, 1, 9'h000};

        ifa.in_valid = 1'b1; ifa.in_data = 8'h41; ifa.in_is_cmd = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.in_is_cmd = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_e", 32'(a_e), 32'd0);
        check("rst_rs", 32'(a_rs), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_ready", 32'(ifa.in_ready), 32'd0);
        check("rst_init", 32'(a_init), 32'd0);
        check("rst_cursor", 32'({a_row, a_col}), 32'd0);
        check("rst_b", 32'({b_e, b_rs, b_data, b_init, b_row, b_col}), 32'd0);

        // 0x41 is offered throughout reset and init and must be held off, not lost.
        pq.delete(); sq.delete();
        rst_n = 1'b1;
        check_init("boot");
        n = 0;
        while (!ifa.in_ready && n < BOUND) begin @(negedge clk); n++; end
        check("held_init_first", 32'(a_init), 32'd1);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        lat = 1;
        while (!ifa.in_ready && lat < BOUND) begin @(negedge clk); lat++; end
        check("held_latency", 32'(lat), 32'd9);
        check("held_npulses", 32'(pq.size()), 32'd5);
        check("held_pulse", (pq.size() > 4) ? 32'(pq[4]) : 32'h1FF, 32'h141);
        check("held_col", 32'(a_col), 32'd1);

        for (int i = 0; i < 12; i++) begin
            send_a(vt[i].c, vt[i].d, $sformatf("vec%0d", i), lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("vec%0d row", i), 32'(a_row), 32'(vt[i].row));
            check($sformatf("vec%0d col", i), 32'(a_col), 32'(vt[i].col));
            check($sformatf("vec%0d npulses", i), 32'(pq.size()), 32'(vt[i].npulse));
            check($sformatf("vec%0d pulse0", i), (pq.size() > 0) ? 32'(pq[0]) : 32'h1FF, 32'({!vt[i].c, vt[i].d}));
            if (vt[i].npulse == 2)
                check($sformatf("vec%0d line_cmd", i), (pq.size() > 1) ? 32'(pq[1]) : 32'h1FF, 32'(vt[i].p2));
            m_row = int'(vt[i].row);
            m_col = int'(vt[i].col);
        end

        for (int i = 0; i < 32; i++) do_txn(1'b0, 8'h41 + 8'(i % 26), $sformatf("stream%0d", i));

        for (int i = 0; i < 100; i++) begin
            logic c;
            logic [7:0] d;
            c = ($urandom_range(0, 3) == 0);
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_txn(c, d, $sformatf("rnd%0d", i));
        end

        send_b(1'b1, 8'h8F, 1'b0, 4'd7);
        send_b(1'b1, 8'hCA, 1'b1, 4'd7);
        send_b(1'b0, 8'h20, 1'b0, 4'd0);
        send_b(1'b0, 8'h21, 1'b0, 4'd1);

        // Reset while E is high: everything drops at once, then init replays.
        @(negedge clk);
        ifa.in_valid = 1'b1; ifa.in_data = 8'h5A; ifa.in_is_cmd = 1'b0;
        n = 0;
        while (!a_e && n < BOUND) begin @(negedge clk); n++; end
        check("midrst_e_seen", 32'(a_e), 32'd1);
        ifa.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_e", 32'(a_e), 32'd0);
        check("midrst_outputs", 32'({a_rs, a_data, ifa.in_ready, a_init, a_row, a_col}), 32'd0);
        repeat (2) @(negedge clk);
        pq.delete(); sq.delete();
        rst_n = 1'b1;
        check_init("replay");
        m_row = 0; m_col = 0;
        do_txn(1'b0, 8'h35, "post_replay");

        check("e_data_stable", 32'(stab_err), 32'd0);
        check("no_ready_before_init", 32'(ready_err), 32'd0);
        check("rw_low", 32'(rw_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
